store_buffer: RTL

//  Store-side counterpart of the load data filter: accepts SB/SH/SW from the MEM stage,

---
 rtl/rv_mem_pkg.sv | 19 +
 rtl/sb_fifo.sv | 58 +++++
 rtl/store_buffer.sv | 101 ++++++++++
 3 files changed

// File: rtl/rv_mem_pkg.sv
// Shared memory-side definitions: func3 encodings and the store beat record.
package rv_mem_pkg;

    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Beat address field is sized for the widest supported byte address.
    localparam int BEAT_AW = 32;

    typedef struct packed {
        logic [BEAT_AW-1:0] addr;
        logic [31:0]        wdata;
        logic [3:0]         wstrb;
    } beat_t;

endpackage

// File: rtl/sb_fifo.sv
// Beat FIFO: up to two pushes and one pop per cycle, registered occupancy count.
// push1_i is only meaningful together with push0_i (beat1 follows beat0).
module sb_fifo
    import rv_mem_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     push0_i,
    input  logic                     push1_i,
    input  beat_t                    din0_i,
    input  beat_t                    din1_i,
    input  logic                     pop_i,
    output beat_t                    dout_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    beat_t          mem_q [DEPTH];
    logic [PW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d, wptr1;
    logic [CW-1:0]  count_q, count_d;
    logic [1:0]     npush;

    // Pointer and count next-state; the count adds pushes and drops the pop in one step.
    always_comb begin
        npush   = {1'b0, push0_i} + {1'b0, push1_i};
        wptr1   = wptr_q + PW'(1);
        wptr_d  = wptr_q + PW'(npush);
        rptr_d  = rptr_q + PW'(pop_i);
        count_d = count_q + CW'(npush) - CW'(pop_i);
    end

    // Storage needs no reset: an empty count makes stale entries unreachable.
    always_ff @(posedge clk_i) begin
        if (push0_i) mem_q[wptr_q] <= din0_i;
        if (push1_i) mem_q[wptr1]  <= din1_i;
    end

    // Pointers and count; reset flushes every queued beat.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    assign dout_o  = mem_q[rptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/store_buffer.sv
// Store buffer: lane-aligns SB/SH/SW into word beats with strobes, splits stores that
// cross a word boundary into two beats, and drains them in order over req/ack.
module store_buffer
    import rv_mem_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = BEAT_AW
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   st_valid_i,
    output logic                   st_ready_o,
    input  logic [2:0]             st_func3_i,
    input  logic [AW-1:0]          st_addr_i,
    input  logic [31:0]            st_data_i,
    output logic                   st_err_o,
    output logic                   mem_req_o,
    output logic [AW-1:0]          mem_addr_o,
    output logic [31:0]            mem_wdata_o,
    output logic [3:0]             mem_wstrb_o,
    input  logic                   mem_ack_i,
    output logic                   sb_empty_o,
    output logic [$clog2(DEPTH):0] sb_count_o
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [CW-1:0] count;
    beat_t         head, beat0, beat1;
    logic          legal, accept, push0, push1, pop;
    logic [3:0]    mask;
    logic [31:0]   dmask;
    logic [63:0]   d64;
    logic [7:0]    s8;
    logic [1:0]    k;
    logic [AW-1:0] waddr0, waddr1;
    logic          st_err_q, st_err_d;

    // Formatter: size mask from func3, then shift data and strobes by the byte offset.
    always_comb begin
        k     = st_addr_i[1:0];
        legal = 1'b1;
        case (st_func3_i)
            F3_SB:   mask = 4'b0001;
            F3_SH:   mask = 4'b0011;
            F3_SW:   mask = 4'b1111;
            default: begin
                mask  = 4'b0000;
                legal = 1'b0;
            end
        endcase
        dmask  = st_data_i & {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
        d64    = {32'b0, dmask} << {k, 3'b000};
        s8     = {4'b0, mask} << k;
        waddr0 = {st_addr_i[AW-1:2], 2'b00};
        waddr1 = waddr0 + AW'(4);
        beat0       = '0;
        beat0.addr  = BEAT_AW'(waddr0);
        beat0.wdata = d64[31:0];
        beat0.wstrb = s8[3:0];
        beat1       = '0;
        beat1.addr  = BEAT_AW'(waddr1);
        beat1.wdata = d64[63:32];
        beat1.wstrb = s8[7:4];
    end

    // Two free slots are always reserved so a split store never needs a partial push.
    assign st_ready_o = rst_n_i && (count <= CW'(DEPTH - 2));
    assign accept     = st_valid_i && st_ready_o;
    assign push0      = accept && legal;
    assign push1      = push0 && (s8[7:4] != 4'b0000);
    assign pop        = mem_req_o && mem_ack_i;
    assign st_err_d   = accept && !legal;

    // Illegal store flag: single-cycle pulse following the accepting edge.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) st_err_q <= 1'b0;
        else          st_err_q <= st_err_d;
    end

    sb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .push0_i (push0),
        .push1_i (push1),
        .din0_i  (beat0),
        .din1_i  (beat1),
        .pop_i   (pop),
        .dout_o  (head),
        .count_o (count)
    );

    assign st_err_o    = st_err_q;
    assign mem_req_o   = (count != '0);
    assign sb_empty_o  = (count == '0);
    assign sb_count_o  = count;
    assign mem_addr_o  = head.addr[AW-1:0];
    assign mem_wdata_o = head.wdata;
    assign mem_wstrb_o = head.wstrb;

endmodule
